sequenciador_jogada: RTL

// - Moore FSM that sequences loading of the four 3-bit coordinate registers of one move:

---
 rtl/sequenciador_jogada.sv | 100 ++++++++++
 1 files changed

// File: rtl/sequenciador_jogada.sv
// Moore FSM sequencing the four coordinate-register loads of one move, with cancel and
// per-coordinate wait timeout; all outputs are registered decodes of the next state.
module sequenciador_jogada #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int CW             = 13
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       iniciar,
  input  logic       botao,
  input  logic       cancelar,
  output logic       zera_regs,
  output logic       en_col_orig,
  output logic       en_lin_orig,
  output logic       en_col_dest,
  output logic       en_lin_dest,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ESP_CO  = 4'd2,
    REG_CO  = 4'd3,
    ESP_LO  = 4'd4,
    REG_LO  = 4'd5,
    ESP_CD  = 4'd6,
    REG_CD  = 4'd7,
    ESP_LD  = 4'd8,
    REG_LD  = 4'd9,
    FIM     = 4'd10,
    TOUT    = 4'd14
  } estado_t;

  localparam bit            TIMEOUT_EN = (TIMEOUT_CICLOS != 0);
  localparam logic [CW-1:0] LIMITE     = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          esp;

  always_comb begin
    state_d = state_q;
    esp     = 1'b0;
    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARA;
      PREPARA: state_d = ESP_CO;
      ESP_CO, ESP_LO, ESP_CD, ESP_LD: begin
        esp = 1'b1;
        // Each REG state's code is its ESP state's code plus one.
        if (cancelar)                              state_d = PREPARA;
        else if (botao)                            state_d = estado_t'(state_q + 4'd1);
        else if (TIMEOUT_EN && (cnt_q == LIMITE))  state_d = TOUT;
      end
      REG_CO:  state_d = ESP_LO;
      REG_LO:  state_d = ESP_CD;
      REG_CD:  state_d = ESP_LD;
      REG_LD:  state_d = FIM;
      FIM, TOUT: if (iniciar) state_d = PREPARA;
      default: state_d = INICIAL;
    endcase
  end

  // Counter only advances while remaining in the same wait state; saturates instead of wrapping.
  always_comb begin
    cnt_d = '0;
    if (TIMEOUT_EN && esp && (state_d == state_q))
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= INICIAL;
      cnt_q       <= '0;
      zera_regs   <= 1'b0;
      en_col_orig <= 1'b0;
      en_lin_orig <= 1'b0;
      en_col_dest <= 1'b0;
      en_lin_dest <= 1'b0;
      pronto      <= 1'b0;
      timeout     <= 1'b0;
      db_estado   <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      zera_regs   <= (state_d == PREPARA);
      en_col_orig <= (state_d == REG_CO);
      en_lin_orig <= (state_d == REG_LO);
      en_col_dest <= (state_d == REG_CD);
      en_lin_dest <= (state_d == REG_LD);
      pronto      <= (state_d == FIM);
      timeout     <= (state_d == TOUT);
      db_estado   <= state_d;
    end
  end

endmodule
